// File: rtl/seq_pkg.sv
// Shared types and constants for the MSB-first word serializer.
package seq_pkg;

    localparam int unsigned SEQ_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_parity_gen.sv
// Even-parity generator (XOR reduce) for the serializer parity bit.
// The module exists only in builds with SER_PARITY_EN defined.
`ifdef SER_PARITY_EN
module seq_parity_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             parity_o
);

    assign parity_o = ^data_i;

endmodule
`endif

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter, MSB first, one bit per cycle, with gapless back-to-back frames.
// Define SER_PARITY_EN to append an even-parity bit after the LSB of every frame.
module seq_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             load_c;

`ifdef SER_PARITY_EN
    logic par_q, par_d, par_c;

    seq_parity_gen #(
        .WIDTH (WIDTH)
    ) u_parity_gen (
        .data_i   (din),
        .parity_o (par_c)
    );
`endif

    // A word is only taken while ready, i.e. in IDLE or on the final frame bit.
    assign load_c = din_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // cnt_q counts frame data bits already presented on bit_out (1..WIDTH).
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bit_d   = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b0;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            SHIFT: begin
                if (cnt_q < CNT_LAST) begin
                    bit_d   = sr_q[WIDTH-1];
                    valid_d = 1'b1;
                    sr_d    = {sr_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
`ifdef SER_PARITY_EN
                    state_d = PAR;
                    bit_d   = par_q;
                    valid_d = 1'b1;
`else
                    state_d = IDLE;
`endif
                    sr_d    = '0;
                    cnt_d   = '0;
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load on the final bit overrides the frame ending, giving a gapless stream.
        if (load_c) begin
            state_d = SHIFT;
            bit_d   = din[WIDTH-1];
            valid_d = 1'b1;
            sr_d    = {din[WIDTH-2:0], 1'b0};
            cnt_d   = CNT_W'(1);
`ifdef SER_PARITY_EN
            par_d   = par_c;
`endif
        end

`ifdef SER_PARITY_EN
        ready_d = (state_d == IDLE) || (state_d == PAR);
`else
        ready_d = (state_d == IDLE) || ((state_d == SHIFT) && (cnt_d == CNT_LAST));
`endif
    end

    assign din_ready = ready_q;
    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign busy      = valid_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: per-cycle vector table plus detector and parity sequences.
module tb_seq_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] din;
        logic       chk;
        logic       er;
        logic       ev;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    seq_serializer #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream detector for the pattern 0110; pulses the cycle after the last bit arrives.
    logic [2:0] hist;
    logic       det;
    always @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            det  <= 1'b0;
        end else begin
            det <= bit_valid && ({hist, bit_out} == 4'b0110);
            if (bit_valid) hist <= {hist[1:0], bit_out};
        end
    end

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst       = r;
        din_valid = dv;
        din       = d;
        @(negedge clk);
    endtask

    function automatic void add(input logic r, input logic dv, input logic [7:0] d,
                                input logic c, input logic er, input logic ev, input logic eb);
        vec_t v;
        v.rst = r; v.dv = dv; v.din = d; v.chk = c; v.er = er; v.ev = ev; v.eb = eb;
        vecs.push_back(v);
    endfunction

    logic [7:0] pat;
    logic [8:0] pat9;

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;

`ifndef SER_PARITY_EN
        // Single frame 0110_0110 loaded in cycle 1, bits in cycles 2-9, idle in 10.
        add(1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h66, 1, 1, 0, 0);
        pat = 8'b0110_0110;
        for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 1, k == 7, 1, pat[7-k]);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        // Back-to-back F0 then 0F with din_valid held high through the first frame.
        add(0, 1, 8'hF0, 1, 1, 0, 0);
        pat = 8'hF0;
        for (int k = 0; k < 8; k++) add(0, 1, 8'h0F, 1, k == 7, 1, pat[7-k]);
        pat = 8'h0F;
        for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 1, k == 7, 1, pat[7-k]);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        // Mid-frame din_valid pulse with AA is ignored.
        pat = 8'h3C;
        add(0, 1, pat, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++)
            add(0, k == 2, (k == 2) ? 8'hAA : 8'h00, 1, k == 7, 1, pat[7-k]);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        // Reset in cycle 4 of a 5A frame aborts it; fresh C3 frame follows.
        pat = 8'h5A;
        add(0, 1, pat, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 0, 1, pat[7]);
        add(0, 0, 8'h00, 1, 0, 1, pat[6]);
        add(1, 1, 8'hFF, 1, 0, 1, pat[5]);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        pat = 8'hC3;
        add(0, 1, pat, 1, 1, 0, 0);
        for (int k = 0; k < 8; k++) add(0, 0, 8'h00, 1, k == 7, 1, pat[7-k]);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        // Reset wins over a simultaneous din_valid while idle.
        add(1, 1, 8'hFF, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].dv, vecs[i].din);
            if (vecs[i].chk) begin
                chk("din_ready", i, din_ready, vecs[i].er);
                chk("bit_valid", i, bit_valid, vecs[i].ev);
                chk("bit_out",   i, bit_out,   vecs[i].eb);
                chk("busy",      i, busy,      vecs[i].ev);
            end
        end
`else
        // Parity frame: 0000_0111 then even-parity bit 1, valid in cycles 2-10.
        step(1, 0, 8'h00);
        step(1, 0, 8'h00);
        step(0, 1, 8'b0000_0111);
        chk("par_ready_c1", 1, din_ready, 1'b1);
        pat9 = 9'b0_0000_1111;
        for (int k = 0; k < 9; k++) begin
            step(0, 0, 8'h00);
            chk("par_valid", k + 2, bit_valid, 1'b1);
            chk("par_bit",   k + 2, bit_out,   pat9[8-k]);
            chk("par_ready", k + 2, din_ready, k == 8);
        end
        step(0, 0, 8'h00);
        chk("par_idle_valid", 11, bit_valid, 1'b0);
        chk("par_idle_busy",  11, busy,      1'b0);
`endif

        // Serializer feeding the 0110 detector with 0110_0000: single pulse in cycle 6.
        step(1, 0, 8'h00);
        step(0, 1, 8'b0110_0000);
        chk("det_c1", 1, det, 1'b0);
        for (int c = 2; c <= 12; c++) begin
            step(0, 0, 8'h00);
            chk("det", c, det, c == 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning number of data bits per frame (legal range 2..32).
REQ-002 SHALL provide port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL provide port din, input, WIDTH, parallel word to serialize.
REQ-005 SHALL provide port din_valid, input, 1, upstream asserts when din holds a word.
REQ-006 SHALL provide port din_ready, output, 1, block can accept din this cycle.
REQ-007 SHALL provide port bit_out, output, 1, serial bit feeding the downstream sequence detector input i.
REQ-008 SHALL provide port bit_valid, output, 1, bit_out carries a frame bit this cycle.
REQ-009 SHALL provide port busy, output, 1, a frame is in progress.

Function
REQ-010 SHALL implement states IDLE and SHIFT, plus PAR when SER_PARITY_EN is defined.
REQ-011 SHALL accept a word on any cycle where din_valid && din_ready; this is the load cycle N.
REQ-012 SHALL present the MSB of the loaded word on bit_out with bit_valid=1 in cycle N+1 (latency 1), then successive bits MSB-first, one per cycle, with the LSB in cycle N+WIDTH.
REQ-013 SHALL drive din_ready=1 in IDLE and in the cycle carrying the final frame bit, and 0 otherwise.
REQ-014 SHALL, when a load coincides with the final frame bit, output the new MSB in the immediately following cycle, giving a gapless stream.
REQ-015 SHALL, when no load occurs on the final bit, return to IDLE with bit_out=0, bit_valid=0, and busy=0 on the next cycle.
REQ-016 SHALL keep busy=1 exactly while bit_valid=1.
REQ-017 SHALL ignore din and din_valid whenever din_ready=0; the captured word is never modified mid-frame.
REQ-018 SHALL track frame position with a bit counter of width $clog2(WIDTH+1), with no wrap-around beyond the frame length.
REQ-019 SHALL hold bit_out=0 whenever bit_valid=0.

Reset
REQ-020 SHALL, when rst=1 at a clock edge, force state=IDLE, bit_out=0, bit_valid=0, busy=0, clear the counter and shift register, and drive din_ready=1 from the next cycle.
REQ-021 SHALL abort a frame on reset mid-frame, emitting no further bits of that frame.
REQ-022 SHALL give rst priority over a simultaneous din_valid; no word is captured in that cycle.

Configuration
REQ-023 SHALL, with macro SER_PARITY_EN defined, append one even-parity bit (XOR of the WIDTH data bits) in state PAR after the LSB, making the frame WIDTH+1 cycles; the parity cycle is then the final bit for REQ-013 and REQ-014.
REQ-024 SHALL, without SER_PARITY_EN, have no PAR state and no parity logic, with a frame of exactly WIDTH cycles.

Structure
REQ-025 SHALL place the state enum (IDLE, SHIFT, PAR) and the default WIDTH constant in shared package seq_pkg.
REQ-026 SHALL instantiate one sub-module, seq_parity_gen (combinational XOR reduce), only when SER_PARITY_EN is defined; all else SHALL be flat.

Verification
REQ-027 SHALL cover: after reset, din=8'b0110_0110 loaded at cycle 1 -> bit_out 0,1,1,0,0,1,1,0 with bit_valid=1 in cycles 2-9, busy=0 in cycle 10.
REQ-028 SHALL cover: back-to-back words 8'hF0 then 8'h0F with din_valid held high -> 16 consecutive valid bits 1111000000001111, din_ready=1 only in cycles 1 and 9.
REQ-029 SHALL cover: rst=1 in cycle 4 of a frame -> bit_valid=0 and bit_out=0 from cycle 5, din_ready=1 from cycle 5, and the next load begins a fresh frame with its MSB.
REQ-030 SHALL cover: din_valid pulsed with din=8'hAA mid-frame while din_ready=0 -> ignored, frame bits unchanged.
REQ-031 SHALL cover: with SER_PARITY_EN, din=8'b0000_0111 -> data bits followed by parity bit 1, for 9 valid cycles.
REQ-032 SHALL cover: serializer driving the downstream detector with 8'b0110_0000 -> detector output pulses once, at the cycle after it receives the fourth serial bit.
